// File: rtl/g2b_sync_decoder_if.sv
// rtl/g2b_sync_decoder_if.sv - Gray-input / binary-output bus for the Gray-to-binary sync decoder.
// Optional err_cnt signal present only when G2B_ERR_CNT_EN is defined.
interface g2b_sync_decoder_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] gray_in;
  logic             en;
  logic [WIDTH-1:0] binary_out;
  logic             bin_valid;
  logic             step_err;
`ifdef G2B_ERR_CNT_EN
  logic [7:0]       err_cnt;
`endif

  modport master (
    output gray_in,
    output en,
    input  binary_out,
    input  bin_valid,
    input  step_err
`ifdef G2B_ERR_CNT_EN
    ,
    input  err_cnt
`endif
  );

  modport slave (
    input  gray_in,
    input  en,
    output binary_out,
    output bin_valid,
    output step_err
`ifdef G2B_ERR_CNT_EN
    ,
    output err_cnt
`endif
  );
endinterface

// File: rtl/g2b_sync_decoder.sv
// rtl/g2b_sync_decoder.sv - Synchronizes a Gray bus and converts it to registered binary with change/error strobes.
// Optional saturating step-error counter enabled by G2B_ERR_CNT_EN.
module g2b_sync_decoder #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  g2b_sync_decoder_if.slave bus
);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] gs;
  logic [WIDTH-1:0] bin_next;
  logic [WIDTH-1:0] diff;
  logic             multi_step;
  logic             update;

  logic [WIDTH-1:0] prev_gray;
  logic             primed;
  logic [WIDTH-1:0] binary_q;
  logic             bin_valid_q;
  logic             step_err_q;

  // Free-running chain: never gated by en so it always tracks the source.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= bus.gray_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign gs = sync_q[SYNC_STAGES-1];

  // Each binary bit is the parity of the Gray bits at and above it.
  always_comb begin
    bin_next = '0;
    for (int i = 0; i < WIDTH; i++) bin_next[i] = ^(gs >> i);
  end

  assign diff       = gs ^ prev_gray;
  assign multi_step = |(diff & (diff - ONE));
  assign update     = bus.en && (!primed || (gs != prev_gray));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_gray   <= '0;
      primed      <= 1'b0;
      binary_q    <= '0;
      bin_valid_q <= 1'b0;
      step_err_q  <= 1'b0;
    end else begin
      bin_valid_q <= 1'b0;
      step_err_q  <= 1'b0;
      if (update) begin
        binary_q    <= bin_next;
        prev_gray   <= gs;
        primed      <= 1'b1;
        bin_valid_q <= 1'b1;
        step_err_q  <= primed && multi_step;
      end
    end
  end

  assign bus.binary_out = binary_q;
  assign bus.bin_valid  = bin_valid_q;
  assign bus.step_err   = step_err_q;

`ifdef G2B_ERR_CNT_EN
  logic [7:0] err_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt_q <= 8'd0;
    end else if (update && primed && multi_step && (err_cnt_q != 8'hFF)) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign bus.err_cnt = err_cnt_q;
`endif
endmodule

// File: tb/tb_g2b_sync_decoder.sv
// tb/tb_g2b_sync_decoder.sv - Self-checking bench for g2b_sync_decoder (G2B_ERR_CNT_EN aware).
module tb_g2b_sync_decoder;
  localparam int W = 4;
  localparam int S = 2;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  g2b_sync_decoder_if #(.WIDTH(W)) bus_if ();

  g2b_sync_decoder #(.WIDTH(W), .SYNC_STAGES(S)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: S-deep delay line of sampled inputs plus last-accepted value.
  int dq[$];
  int m_prev;
  bit m_primed;
  int exp_bin;
  bit exp_valid;
  bit exp_err;
  int exp_cnt;

  function automatic int g2b(input int g);
    int b;
    b = g;
    for (int s = 1; s < W; s++) b = b ^ (g >> s);
    return b & ((1 << W) - 1);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    dq.delete();
    for (int i = 0; i < S; i++) dq.push_back(0);
    m_prev    = 0;
    m_primed  = 1'b0;
    exp_bin   = 0;
    exp_valid = 1'b0;
    exp_err   = 1'b0;
    exp_cnt   = 0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_bin"},   32'(bus_if.binary_out), 32'(exp_bin));
    check({tag, "_valid"}, 32'(bus_if.bin_valid),  32'(exp_valid));
    check({tag, "_err"},   32'(bus_if.step_err),   32'(exp_err));
`ifdef G2B_ERR_CNT_EN
    check({tag, "_cnt"},   32'(bus_if.err_cnt),    32'(exp_cnt));
`endif
  endtask

  task automatic tick(input string tag);
    int g;
    @(posedge clk);
    g = dq.pop_front();
    dq.push_back(int'(bus_if.gray_in));
    exp_valid = 1'b0;
    exp_err   = 1'b0;
    if (bus_if.en && (!m_primed || g != m_prev)) begin
      exp_valid = 1'b1;
      exp_err   = m_primed && ($countones(g ^ m_prev) > 1);
      exp_bin   = g2b(g);
      m_prev    = g;
      m_primed  = 1'b1;
      if (exp_err && exp_cnt < 255) exp_cnt++;
    end
    #1;
    check_outputs(tag);
  endtask

  task automatic hold(input int gray, input int n, input string tag);
    bus_if.gray_in = W'(gray);
    for (int i = 0; i < n; i++) tick(tag);
  endtask

  int walk[16] = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8};

  initial begin
    int cur;
    checks        = 0;
    failures      = 0;
    rst           = 1'b1;
    bus_if.gray_in = '0;
    bus_if.en      = 1'b0;
    model_reset();
    #12;
    check_outputs("reset");

    // Release, keep disabled two edges so the first enabled edge is the third.
    rst = 1'b0;
    tick("rel1");
    tick("rel2");
    bus_if.en = 1'b1;
    tick("rel3");
    check("first_pulse", 32'(bus_if.bin_valid), 32'd1);
    hold(0, 3, "idle");

    foreach (walk[i]) hold(walk[i], 4, "walk");
    check("walk_end", 32'(bus_if.binary_out), 32'd15);

    hold(0, 4, "wrap");
    check("wrap_end", 32'(bus_if.binary_out), 32'd0);

    hold(1, 4, "pre_jump");
    hold(6, 4, "jump");
    check("jump_bin", 32'(bus_if.binary_out), 32'd4);

    for (int j = 0; j < 300; j++) hold((j % 2 == 0) ? 1 : 6, 3, "jumps");
`ifdef G2B_ERR_CNT_EN
    check("cnt_sat", 32'(bus_if.err_cnt), 32'd255);
`endif

    hold(0, 4, "pre_dis");
    bus_if.en = 1'b0;
    hold(1, 4, "dis1");
    hold(3, 4, "dis2");
    bus_if.en = 1'b1;
    tick("reen");
    check("reen_bin", 32'(bus_if.binary_out), 32'd2);
    check("reen_err", 32'(bus_if.step_err), 32'd1);
    hold(3, 3, "post_reen");

    hold(7, 6, "pre_rst");
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs("mid_rst");
    #1;
    rst = 1'b0;
    bus_if.en = 1'b0;
    tick("mrel1");
    tick("mrel2");
    bus_if.en = 1'b1;
    tick("mrel3");
    check("mrel_bin", 32'(bus_if.binary_out), 32'd5);
    check("mrel_err", 32'(bus_if.step_err), 32'd0);

    cur = 7;
    for (int k = 0; k < 200; k++) begin
      case ($urandom_range(0, 3))
        0: cur = cur ^ (1 << $urandom_range(0, W - 1));
        1: cur = int'($urandom_range(0, (1 << W) - 1));
        default: ;
      endcase
      bus_if.en = ($urandom_range(0, 4) != 0);
      hold(cur, int'($urandom_range(1, 4)), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
